// File: rtl/pulse_stretch_scheduler.sv
// pulse_stretch_scheduler
// Shares one stretched-pulse output line among NCH requesters. Rising edges on
// req are latched per channel as pending requests; one pending channel is
// granted round-robin and pulse_out is driven for that channel's configured
// length. A guard gap of GAP idle cycles follows each pulse before the next
// grant (the grant itself takes one further IDLE cycle).
//
// Ports
//   clk       in   single clock
//   reset_n   in   asynchronous, active-low reset
//   req       in   [NCH]     request lines, a rising edge is one request
//   len_cfg   in   [NCH*LW]  per-channel pulse length, ch i at [i*LW +: LW]
//   en        in   1 = new grants allowed
//   ovf_clr   in   [NCH]     one-cycle strobe clearing overflow[i]
//   pulse_out out  stretched output pulse (registered)
//   pulse_id  out  [IDW]     channel owning the current/last pulse
//   busy      out  high while a pulse or its guard gap is in progress
//   pending   out  [NCH]     latched, not-yet-served requests
//   overflow  out  [NCH]     sticky: request arrived while already pending
module pulse_stretch_scheduler #(
  parameter int NCH = 4,
  parameter int LW  = 8,
  parameter int GAP = 2,
  parameter int IDW = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*LW-1:0] len_cfg,
  input  logic              en,
  input  logic [NCH-1:0]    ovf_clr,
  output logic              pulse_out,
  output logic [IDW-1:0]    pulse_id,
  output logic              busy,
  output logic [NCH-1:0]    pending,
  output logic [NCH-1:0]    overflow
);

  // Counter holds both a pulse length (up to 2^LW-1) and a gap count (up to 255).
  localparam int CW = LW + 8;
  localparam logic [CW-1:0] GAP_LAST = (GAP > 0) ? CW'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [LW-1:0]   len_q;
  logic [IDW-1:0]  last_grant;
  logic [NCH-1:0]  req_q;
  logic [NCH-1:0]  rise;
  logic [NCH-1:0]  rot;
  logic [IDW:0]    shamt;
  logic            sel_hit;
  logic [IDW-1:0]  sel_ch;
  logic [LW-1:0]   sel_len;
  logic            do_grant;
  logic [NCH-1:0]  grant;

  assign rise = req & ~req_q;

  // Round-robin pick: rotate pending so bit 0 is channel last_grant+1, then
  // take the lowest set bit and map it back to a channel number.
  always_comb begin
    shamt   = (IDW+1)'(last_grant) + (IDW+1)'(1);
    rot     = NCH'({pending, pending} >> shamt);
    sel_hit = 1'b0;
    sel_ch  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (!sel_hit && rot[k]) begin
        sel_hit = 1'b1;
        sel_ch  = IDW'((32'(last_grant) + 32'd1 + k) % NCH);
      end
    end
  end

  // Length of the selected channel; zero is treated as a one-cycle pulse.
  always_comb begin
    sel_len = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sel_ch == IDW'(i)) begin
        sel_len = len_cfg[i*LW +: LW];
      end
    end
    if (sel_len == '0) begin
      sel_len = LW'(1);
    end
  end

  assign do_grant = (state == S_IDLE) && en && sel_hit;

  always_comb begin
    grant = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      grant[i] = do_grant && (sel_ch == IDW'(i));
    end
  end

  // Request capture. A new rise beats a same-cycle grant clear, and only a
  // rise that finds the channel still pending (and not being granted) is an
  // overflow; that extra request is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q    <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      req_q    <= req;
      pending  <= (pending & ~grant) | rise;
      overflow <= (overflow & ~ovf_clr) | (rise & pending & ~grant);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      len_q      <= '0;
      last_grant <= IDW'(NCH - 1);
      pulse_out  <= 1'b0;
      pulse_id   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (do_grant) begin
            pulse_id   <= sel_ch;
            last_grant <= sel_ch;
            len_q      <= sel_len;
            cnt        <= CW'(1);
            pulse_out  <= 1'b1;
            busy       <= 1'b1;
            state      <= S_PULSE;
          end
        end
        S_PULSE: begin
          if (cnt == CW'(len_q)) begin
            pulse_out <= 1'b0;
            cnt       <= '0;
            if (GAP == 0) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              state <= S_GAP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state     <= S_IDLE;
          cnt       <= '0;
          pulse_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_stretch_scheduler.sv
// Bench for pulse_stretch_scheduler. Stimulus pushes the expected pulse
// (channel, start cycle, length) into a queue; a monitor process detects each
// completed pulse on pulse_out and compares it against the queue head.
// A second instance with GAP=0 covers back-to-back scheduling.
module tb_pulse_stretch_scheduler;

  localparam int NCH = 4;
  localparam int LW  = 8;
  localparam int IDW = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCH-1:0]    req = '0;
  logic [LW-1:0]     len [NCH];
  logic [NCH*LW-1:0] len_cfg;
  logic              en = 1'b1;
  logic [NCH-1:0]    ovf_clr = '0;
  logic              pulse_out;
  logic [IDW-1:0]    pulse_id;
  logic              busy;
  logic [NCH-1:0]    pending;
  logic [NCH-1:0]    overflow;

  logic [NCH-1:0]    g_req = '0;
  logic              g_pulse;
  logic [IDW-1:0]    g_id;
  logic              g_busy;
  logic [NCH-1:0]    g_pending;
  logic [NCH-1:0]    g_overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int id;
    int start;
    int len;
  } exp_t;
  exp_t sb[$];

  assign len_cfg = {len[3], len[2], len[1], len[0]};

  pulse_stretch_scheduler #(.NCH(NCH), .LW(LW), .GAP(2), .IDW(IDW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .len_cfg  (len_cfg),
    .en       (en),
    .ovf_clr  (ovf_clr),
    .pulse_out(pulse_out),
    .pulse_id (pulse_id),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  pulse_stretch_scheduler #(.NCH(NCH), .LW(LW), .GAP(0), .IDW(IDW)) dut_gap0 (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (g_req),
    .len_cfg  ({4{8'd2}}),
    .en       (1'b1),
    .ovf_clr  (4'b0000),
    .pulse_out(g_pulse),
    .pulse_id (g_id),
    .busy     (g_busy),
    .pending  (g_pending),
    .overflow (g_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic ck(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  task automatic push(input int id, input int start, input int ln);
    exp_t e;
    e.id = id;
    e.start = start;
    e.len = ln;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Pulse monitor
  logic mon_prev = 1'b0;
  int   m_start  = 0;
  int   m_id     = 0;
  int   m_len    = 0;

  always @(negedge clk) begin
    exp_t e;
    if (pulse_out && !mon_prev) begin
      m_start = cyc;
      m_id    = int'(pulse_id);
      m_len   = 1;
    end else if (pulse_out) begin
      m_len++;
    end else if (mon_prev) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL pulse_unexpected: got id=%0d start=%0d len=%0d expected no pulse",
                 m_id, m_start, m_len);
      end else begin
        e = sb.pop_front();
        if (e.id != m_id || e.start != m_start || e.len != m_len) begin
          failures++;
          $display("FAIL pulse: got id=%0d start=%0d len=%0d expected id=%0d start=%0d len=%0d",
                   m_id, m_start, m_len, e.id, e.start, e.len);
        end
      end
    end
    mon_prev = pulse_out;
  end

  logic [6:0] g_exp;

  initial begin
    for (int i = 0; i < NCH; i++) len[i] = 8'd3;
    g_exp = 7'b0110110;

    // Reset state
    wait_to(1);
    ck("rst_pulse_out", 32'(pulse_out), 0);
    ck("rst_pulse_id", 32'(pulse_id), 0);
    ck("rst_busy", 32'(busy), 0);
    ck("rst_pending", 32'(pending), 0);
    ck("rst_overflow", 32'(overflow), 0);
    wait_to(2);
    reset_n = 1'b1;

    // Four simultaneous requests, len 3, fresh priority -> 0,1,2,3
    wait_to(10);
    req = 4'b1111;
    push(0, 12, 3); push(1, 18, 3); push(2, 24, 3); push(3, 30, 3);
    wait_to(11);
    ck("all_pending", 32'(pending), 32'h0f);
    req = 4'b0000;
    wait_to(12);
    ck("all_pending_after_grant", 32'(pending), 32'h0e);
    wait_to(35);
    ck("all_busy_end", 32'(busy), 0);
    ck("all_no_ovf", 32'(overflow), 0);

    // Single request on ch0, len 5, req held high (one request only)
    wait_to(40);
    len[0] = 8'd5;
    req = 4'b0001;
    push(0, 42, 5);
    wait_to(41);
    ck("s1_pending", 32'(pending), 32'h1);
    wait_to(42);
    ck("s1_pending_clr", 32'(pending), 0);
    ck("s1_busy_start", 32'(busy), 1);
    ck("s1_id", 32'(pulse_id), 0);
    wait_to(48);
    ck("s1_busy_gap_end", 32'(busy), 1);
    wait_to(49);
    ck("s1_busy_idle", 32'(busy), 0);
    ck("s1_level_no_rereq", 32'(pending), 0);
    req = 4'b0000;

    // Overflow on ch2 while ch1 pulses for 20 cycles
    wait_to(55);
    len[1] = 8'd20;
    req = 4'b0010;
    push(1, 57, 20); push(2, 80, 3);
    wait_to(56); req = 4'b0000;
    wait_to(58); req = 4'b0100;
    wait_to(59); req = 4'b0000;
    wait_to(60); req = 4'b0100;
    wait_to(61);
    req = 4'b0000;
    ck("ovf_set", 32'(overflow), 32'h4);
    ck("ovf_pending", 32'(pending), 32'h4);
    ck("ovf_busy", 32'(busy), 1);
    wait_to(64);
    ck("ovf_sticky", 32'(overflow), 32'h4);
    wait_to(65); ovf_clr = 4'b0100;
    wait_to(66);
    ovf_clr = 4'b0000;
    ck("ovf_cleared", 32'(overflow), 0);
    wait_to(86);
    ck("ovf_done_pending", 32'(pending), 0);
    ck("ovf_done_busy", 32'(busy), 0);

    // len 0 -> one-cycle pulse; len change mid-pulse ignored
    wait_to(90);
    len[3] = 8'd0;
    req = 4'b1000;
    push(3, 92, 1);
    wait_to(91); req = 4'b0000;
    wait_to(100);
    len[3] = 8'd4;
    req = 4'b1000;
    push(3, 102, 4);
    wait_to(101); req = 4'b0000;
    wait_to(103); len[3] = 8'd9;

    // GAP=0 instance: ch0 then ch1, one low cycle between
    wait_to(110);
    g_req = 4'b0011;
    wait_to(111);
    g_req = 4'b0000;
    ck("g0_pending", 32'(g_pending), 32'h3);
    for (int c = 111; c <= 117; c++) begin
      wait_to(c);
      ck("g0_pulse", 32'(g_pulse), 32'(g_exp[c-111]));
      if (c == 114) ck("g0_idle_busy", 32'(g_busy), 0);
      if (c == 115) ck("g0_second_id", 32'(g_id), 1);
    end

    // en gating
    wait_to(120);
    en = 1'b0;
    req = 4'b0101;
    wait_to(121); req = 4'b0000;
    wait_to(123);
    ck("en0_pending", 32'(pending), 32'h5);
    ck("en0_pulse", 32'(pulse_out), 0);
    ck("en0_busy", 32'(busy), 0);
    wait_to(126);
    en = 1'b1;
    push(0, 127, 5); push(2, 135, 3);
    wait_to(132); req = 4'b0001;
    wait_to(133); req = 4'b0000;
    wait_to(136); en = 1'b0;
    wait_to(142);
    ck("en_drop_busy", 32'(busy), 0);
    ck("en_drop_pulse", 32'(pulse_out), 0);
    ck("en_drop_pending", 32'(pending), 32'h1);
    wait_to(143);
    en = 1'b1;
    push(0, 144, 5);

    // Reset during third cycle of a len 8 pulse on ch1
    wait_to(155);
    len[1] = 8'd8;
    req = 4'b0010;
    push(1, 157, 3);
    wait_to(156); req = 4'b0000;
    wait_to(157); req = 4'b0100;
    wait_to(159);
    #2;
    reset_n = 1'b0;
    req = 4'b0000;
    #1;
    ck("arst_pulse", 32'(pulse_out), 0);
    ck("arst_pending", 32'(pending), 0);
    ck("arst_busy", 32'(busy), 0);
    wait_to(160);
    #2;
    reset_n = 1'b1;
    wait_to(163);
    req = 4'b0110;
    push(1, 165, 8); push(2, 176, 3);
    wait_to(164);
    req = 4'b0000;
    ck("post_rst_pending", 32'(pending), 32'h6);
    wait_to(166);
    ck("post_rst_id", 32'(pulse_id), 1);
    ck("post_rst_pending2", 32'(pending), 32'h4);

    wait_to(190);
    ck("sb_drained", 32'(sb.size()), 0);
    ck("end_busy", 32'(busy), 0);
    ck("end_pulse", 32'(pulse_out), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
